// File: rtl/feeder_pkg.sv
// Shared definitions for the pattern feeder.
//   feeder_state_t          : top-level sequencing states
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles before a button level is accepted
//                             (10 ms at 50 MHz)
//   DEFAULT_AUTO_DIV        : clock cycles between auto-mode strobes
//                             (0.5 s at 50 MHz)
package feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        RUN,
        DONE
    } feeder_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_AUTO_DIV        = 25000000;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, counter-based debouncer and a
// rising-edge detector on the debounced level.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   btn_raw in  raw asynchronous button input
//   level   out debounced button level
//   press   out one-cycle pulse on each rising edge of level
module button_debounce
    import feeder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_a;
    logic             sync_b;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= btn_raw;
            sync_b  <= sync_a;
            level_d <= level;
            // The level flips only after the synchronized input has disagreed
            // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement
            // (a bounce back) restarts the count.
            if (sync_b != level) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/pattern_feeder.sv
// Stimulus source for the 01[0*]1 sequence detector. Loads a pattern from the
// switches and shifts it out MSB first, one bit per strobe, either on a
// debounced step press or automatically every AUTO_DIV cycles.
// Ports:
//   clk         in  clock
//   rst         in  synchronous active-high reset
//   sw_pattern  in  pattern switches, sampled on a load
//   btn_load    in  raw load button
//   btn_step    in  raw step button
//   sw_auto     in  1 selects automatic stepping
//   sig_to_test out current pattern bit (registered)
//   ena         out one-cycle strobe: detector consumes sig_to_test now
//   bits_left   out bits not yet emitted
//   done        out pattern exhausted
module pattern_feeder
    import feeder_pkg::*;
#(
    parameter int PATTERN_W       = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int AUTO_DIV        = DEFAULT_AUTO_DIV
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PATTERN_W-1:0]           sw_pattern,
    input  logic                           btn_load,
    input  logic                           btn_step,
    input  logic                           sw_auto,
    output logic                           sig_to_test,
    output logic                           ena,
    output logic [$clog2(PATTERN_W+1)-1:0] bits_left,
    output logic                           done
);

    localparam int BL_W  = $clog2(PATTERN_W + 1);
    localparam int DIV_W = $clog2(AUTO_DIV);

    feeder_state_t        state;
    feeder_state_t        state_next;
    logic [PATTERN_W-1:0] shreg;
    logic [PATTERN_W-1:0] shreg_shifted;
    logic [DIV_W-1:0]     div;
    logic                 div_tc;
    logic                 load_p;
    logic                 step_p;
    logic                 do_load;
    logic                 do_shift;
    logic                 ena_next;
    logic                 div_clear;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_load),
        .level   (),
        .press   (load_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .level   (),
        .press   (step_p)
    );

    assign shreg_shifted = shreg << 1;
    assign div_tc        = (div == DIV_W'(AUTO_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ena is registered: the emit decision is made one cycle ahead, and the
    // shift that consumes the bit happens on the edge ending the ena cycle.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        ena_next   = 1'b0;
        div_clear  = 1'b1;
        case (state)
            IDLE: begin
                if (load_p) begin
                    do_load    = 1'b1;
                    state_next = LOADED;
                end
            end
            LOADED: begin
                if (load_p) begin
                    do_load = 1'b1;
                end else if (sw_auto) begin
                    state_next = RUN;
                end else if (step_p && !ena) begin
                    ena_next = 1'b1;
                end
            end
            RUN: begin
                div_clear = 1'b0;
                if (load_p) begin
                    do_load    = 1'b1;
                    div_clear  = 1'b1;
                    state_next = sw_auto ? RUN : LOADED;
                end else if (!sw_auto) begin
                    div_clear  = 1'b1;
                    state_next = LOADED;
                end else if (div_tc) begin
                    ena_next = 1'b1;
                end
            end
            DONE: begin
                if (load_p) begin
                    do_load    = 1'b1;
                    state_next = LOADED;
                end
            end
            default: state_next = IDLE;
        endcase
        // A load in the same cycle as a pending shift discards the shift.
        do_shift = ena && !do_load;
        if (do_shift && bits_left == BL_W'(1)) begin
            state_next = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bits_left   <= '0;
            sig_to_test <= 1'b0;
            done        <= 1'b0;
            ena         <= 1'b0;
            div         <= '0;
        end else begin
            ena <= ena_next;
            if (div_clear || div_tc) begin
                div <= '0;
            end else begin
                div <= div + DIV_W'(1);
            end
            if (do_load) begin
                shreg       <= sw_pattern;
                bits_left   <= BL_W'(PATTERN_W);
                sig_to_test <= sw_pattern[PATTERN_W-1];
                done        <= 1'b0;
            end else if (do_shift) begin
                shreg       <= shreg_shifted;
                sig_to_test <= shreg_shifted[PATTERN_W-1];
                bits_left   <= bits_left - BL_W'(1);
                if (bits_left == BL_W'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pattern_feeder.sv
module tb_pattern_feeder;
    import feeder_pkg::*;

    localparam int W   = 8;
    localparam int DEB = 4;
    localparam int DIV = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_pattern = '0;
    logic         btn_load = 1'b0;
    logic         btn_step = 1'b0;
    logic         sw_auto = 1'b0;
    logic         sig_to_test;
    logic         ena;
    logic [3:0]   bits_left;
    logic         done;

    pattern_feeder #(
        .PATTERN_W       (W),
        .DEBOUNCE_CYCLES (DEB),
        .AUTO_DIV        (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_pattern  (sw_pattern),
        .btn_load    (btn_load),
        .btn_step    (btn_step),
        .sw_auto     (sw_auto),
        .sig_to_test (sig_to_test),
        .ena         (ena),
        .bits_left   (bits_left),
        .done        (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ena_count = 0;
    int exp_ena = 0;

    // Reference model: the bits still to be presented, front = next bit out.
    bit exp_q[$];
    bit mdone = 1'b0;

    always @(negedge clk) begin
        if (ena === 1'b1) ena_count++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_sig();
        return (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    endfunction

    task automatic model_load(input logic [W-1:0] pat);
        exp_q.delete();
        for (int i = W - 1; i >= 0; i--) exp_q.push_back(pat[i]);
        mdone = 1'b0;
    endtask

    task automatic model_emit();
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) mdone = 1'b1;
        end
        exp_ena++;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_bits_left"}, 32'(bits_left), 32'(exp_q.size()));
        check({tag, "_sig"}, 32'(sig_to_test), 32'(exp_sig()));
        check({tag, "_done"}, 32'(done), 32'(mdone));
    endtask

    task automatic press_load(input logic [W-1:0] pat, input string tag);
        sw_pattern = pat;
        btn_load   = 1'b1;
        tick(DEB + 2);
        check_state({tag, "_early"});
        tick(1);
        model_load(pat);
        check_state(tag);
        check({tag, "_ena"}, 32'(ena), 32'd0);
        btn_load = 1'b0;
        tick(DEB + 6);
    endtask

    task automatic press_step(input bit expect_emit, input string tag);
        btn_step = 1'b1;
        tick(DEB + 2);
        check({tag, "_ena_early"}, 32'(ena), 32'd0);
        tick(1);
        if (expect_emit) begin
            check({tag, "_ena"}, 32'(ena), 32'd1);
            check({tag, "_ena_bit"}, 32'(sig_to_test), 32'(exp_sig()));
            model_emit();
            tick(1);
            check({tag, "_ena_width"}, 32'(ena), 32'd0);
            check_state(tag);
        end else begin
            check({tag, "_no_ena"}, 32'(ena), 32'd0);
            check_state(tag);
        end
        btn_step = 1'b0;
        tick(DEB + 6);
    endtask

    // One auto strobe: two quiet cycles then the strobe carrying the next bit.
    task automatic auto_strobe(input string tag);
        tick(2);
        check({tag, "_quiet"}, 32'(ena), 32'd0);
        tick(1);
        check({tag, "_ena"}, 32'(ena), 32'd1);
        check({tag, "_bit"}, 32'(sig_to_test), 32'(exp_sig()));
        model_emit();
    endtask

    initial begin
        logic [W-1:0] pat;

        // Reset values
        tick(3);
        check("rst_ena", 32'(ena), 32'd0);
        check_state("rst");
        check("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick(2);

        press_step(1'b0, "idle_step");

        // Manual stepping of the reference pattern
        press_load(8'b0101_0001, "load1");
        for (int i = 0; i < W; i++) press_step(1'b1, $sformatf("step%0d", i));
        check("steps_count", 32'(ena_count), 32'(exp_ena));
        press_step(1'b0, "step_after_done");

        // Bouncing step button: only the final steady level counts
        pat = W'($urandom);
        press_load(pat, "load_bounce");
        for (int k = 0; k < 6; k++) begin
            btn_step = (k % 2 == 0);
            tick(2);
        end
        check("bounce_no_ena", 32'(ena_count), 32'(exp_ena));
        btn_step = 1'b1;
        tick(DEB + 2);
        check("bounce_early", 32'(ena), 32'd0);
        tick(1);
        check("bounce_ena", 32'(ena), 32'd1);
        check("bounce_bit", 32'(sig_to_test), 32'(exp_sig()));
        model_emit();
        tick(1);
        check_state("bounce_after");
        btn_step = 1'b0;
        tick(DEB + 6);
        check("bounce_count", 32'(ena_count), 32'(exp_ena));

        // Full auto run
        pat = W'($urandom);
        press_load(pat, "load_auto");
        sw_auto = 1'b1;
        tick(1);
        for (int s = 0; s < W; s++) auto_strobe($sformatf("auto%0d", s));
        tick(1);
        check_state("auto_done");
        tick(6);
        check("auto_count", 32'(ena_count), 32'(exp_ena));
        sw_auto = 1'b0;
        tick(2);

        // Auto run interrupted after three strobes
        pat = W'($urandom);
        press_load(pat, "load_drop");
        sw_auto = 1'b1;
        tick(1);
        for (int s = 0; s < 3; s++) auto_strobe($sformatf("drop%0d", s));
        sw_auto = 1'b0;
        tick(1);
        check_state("drop_after");
        tick(8);
        check("drop_count", 32'(ena_count), 32'(exp_ena));
        check_state("drop_settled");

        // Load and step pressed together with three bits left
        press_step(1'b1, "pre_sim0");
        press_step(1'b1, "pre_sim1");
        check("sim_bits3", 32'(bits_left), 32'd3);
        pat = W'($urandom);
        sw_pattern = pat;
        btn_load = 1'b1;
        btn_step = 1'b1;
        tick(DEB + 3);
        check("sim_no_ena", 32'(ena), 32'd0);
        model_load(pat);
        check_state("sim");
        btn_load = 1'b0;
        btn_step = 1'b0;
        tick(DEB + 6);
        check("sim_count", 32'(ena_count), 32'(exp_ena));

        // Reset in the cycle a second auto strobe is due
        sw_auto = 1'b1;
        tick(1);
        auto_strobe("rr0");
        tick(2);
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        mdone = 1'b0;
        check("rr_ena", 32'(ena), 32'd0);
        check_state("rr");
        check("rr_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        sw_auto = 1'b0;
        tick(3);
        check("rr_count", 32'(ena_count), 32'(exp_ena));
        press_step(1'b0, "rr_step");
        check("rr_state_after", 32'(dut.state), 32'(IDLE));
        check("final_count", 32'(ena_count), 32'(exp_ena));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
